// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl
// Brief    : Execute-side hazard and flush controller. A shifting scoreboard
//            tracks in-flight register writes and stalls issue on RAW
//            conflicts. Taken branches squash wrong-path work, redirect the
//            PC and hold issue for a fixed flush window.
// Revision : 1.0 - initial release
// ============================================================================
module ex_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int IM_AW    = 9,
    parameter int DEPTH    = 4,
    parameter int BR_POS   = 2,
    parameter int BR_FLUSH = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic              id_rs_re_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rt_re_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_we_i,
    input  logic              br_taken_i,
    input  logic [IM_AW-1:0]  br_trgt_i,
    output logic              issue_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              pc_load_o,
    output logic [IM_AW-1:0]  pc_trgt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int FC_W = $clog2(BR_FLUSH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FC_W-1:0]    r_fcnt;
    logic [FC_W-1:0]    w_fcnt_nxt;
    logic [DEPTH-1:0]   r_sb_vld;
    logic [REG_AW-1:0]  r_sb_rd [DEPTH];
    logic               r_pc_load;
    logic [IM_AW-1:0]   r_pc_trgt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_hazard;
    logic               w_idle;
    logic               w_br_take;

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_sb_vld[i] &&
                ((id_rs_re_i && (r_sb_rd[i] == id_rs_i)) ||
                 (id_rt_re_i && (r_sb_rd[i] == id_rt_i)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_idle    = (r_state == IDLE);
    assign w_br_take = w_idle & br_taken_i;
    assign issue_o   = w_idle & id_valid_i & ~w_hazard;
    assign stall_o   = w_idle & id_valid_i & w_hazard;

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            IDLE: begin
                if (br_taken_i) begin
                    w_state_nxt = FLUSH;
                    w_fcnt_nxt  = FC_W'(BR_FLUSH);
                end
            end
            FLUSH: begin
                w_fcnt_nxt = r_fcnt - FC_W'(1);
                if (r_fcnt == FC_W'(1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_fcnt    <= '0;
            r_pc_load <= 1'b0;
            r_pc_trgt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_pc_load <= w_br_take;
            if (w_br_take) begin
                r_pc_trgt <= br_trgt_i;
            end
        end
    end

    // Entries shifted into 1..BR_POS on a branch edge are younger than the
    // branch itself and are dropped along with the instruction issuing now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_sb_rd[i] <= '0;
            end
        end else begin
            r_sb_vld[0] <= issue_o & id_we_i & ~w_br_take;
            r_sb_rd[0]  <= id_rd_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_sb_vld[i] <= r_sb_vld[i-1] & ~(w_br_take & (i <= BR_POS));
                r_sb_rd[i]  <= r_sb_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign flush_o     = (r_state == FLUSH);
    assign pc_load_o   = r_pc_load;
    assign pc_trgt_o   = r_pc_trgt;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_hazard_ctrl
// Brief    : Directed self-checking bench for ex_hazard_ctrl (default build
//            plus a BR_FLUSH=1 / CNT_W=4 build sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic       id_rs_re;
    logic [4:0] id_rt;
    logic       id_rt_re;
    logic [4:0] id_rd;
    logic       id_we;
    logic       br_taken;
    logic [8:0] br_trgt;

    logic        issue1, stall1, flush1, pc_load1;
    logic [8:0]  pc_trgt1;
    logic [15:0] cnt1;
    logic        issue2, stall2, flush2, pc_load2;
    logic [8:0]  pc_trgt2;
    logic [3:0]  cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_re_i(id_rs_re),
        .id_rt_i(id_rt), .id_rt_re_i(id_rt_re), .id_rd_i(id_rd), .id_we_i(id_we),
        .br_taken_i(br_taken), .br_trgt_i(br_trgt),
        .issue_o(issue1), .stall_o(stall1), .flush_o(flush1),
        .pc_load_o(pc_load1), .pc_trgt_o(pc_trgt1), .stall_cnt_o(cnt1)
    );

    ex_hazard_ctrl #(.BR_FLUSH(1), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rs_re_i(id_rs_re),
        .id_rt_i(id_rt), .id_rt_re_i(id_rt_re), .id_rd_i(id_rd), .id_we_i(id_we),
        .br_taken_i(br_taken), .br_trgt_i(br_trgt),
        .issue_o(issue2), .stall_o(stall2), .flush_o(flush2),
        .pc_load_o(pc_load2), .pc_trgt_o(pc_trgt2), .stall_cnt_o(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dec(input logic v, input logic [4:0] rs, input logic rsre,
                       input logic [4:0] rt, input logic rtre,
                       input logic [4:0] rd, input logic we);
        id_valid = v;
        id_rs    = rs;
        id_rs_re = rsre;
        id_rt    = rt;
        id_rt_re = rtre;
        id_rd    = rd;
        id_we    = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        br_taken = 1'b0;
        br_trgt  = '0;
        dec(1, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_issue", issue1, 1);
        check("rst_stall", stall1, 0);
        check("rst_flush", flush1, 0);
        check("rst_pc_load", pc_load1, 0);
        check("rst_pc_trgt", pc_trgt1, 0);
        check("rst_cnt", cnt1, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // RAW stall: writer r5 then dependent reader
        dec(1, 0, 0, 0, 0, 5, 1);
        #1 check("raw_wr_issue", issue1, 1);
        step();
        dec(1, 5, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1 check("raw_stall", stall1, 1);
            step();
        end
        #1;
        check("raw_issue", issue1, 1);
        check("raw_stall_end", stall1, 0);
        check("raw_cnt", cnt1, 4);
        dec(0, 0, 0, 0, 0, 0, 0);
        step();

        // Unread source must not stall; reading it must
        dec(1, 0, 0, 0, 0, 7, 1);
        step();
        dec(1, 3, 1, 7, 0, 0, 0);
        #1;
        check("unread_stall", stall1, 0);
        check("unread_issue", issue1, 1);
        id_rt_re = 1'b1;
        #1 check("read_rt_stall", stall1, 1);
        dec(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();

        // Taken branch with writer r10 issuing in the branch cycle
        dec(1, 0, 0, 0, 0, 9, 1);
        step();
        dec(1, 0, 0, 0, 0, 10, 1);
        br_taken = 1'b1;
        br_trgt  = 9'h01A;
        #1;
        check("br_cycle_issue", issue1, 1);
        check("br_cycle_flush", flush1, 0);
        step();
        br_taken = 1'b0;
        dec(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("br_pc_load", pc_load1, 1);
        check("br_pc_trgt", pc_trgt1, 9'h01A);
        check("br_flush1", flush1, 1);
        check("br_flush_issue", issue1, 0);
        step();
        check("br_pc_load_once", pc_load1, 0);
        check("br_flush2", flush1, 1);
        step();
        check("br_flush3", flush1, 1);
        step();
        check("br_flush_end", flush1, 0);
        dec(1, 10, 1, 0, 0, 0, 0);
        #1;
        check("squash_r10_stall", stall1, 0);
        check("squash_r10_issue", issue1, 1);
        dec(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();

        // Branch concurrent with a hazard, second branch during flush
        dec(1, 0, 0, 0, 0, 3, 1);
        step();
        dec(1, 3, 1, 0, 0, 0, 0);
        br_taken = 1'b1;
        br_trgt  = 9'h055;
        #1;
        check("brhz_stall", stall1, 1);
        check("brhz_issue", issue1, 0);
        step();
        br_trgt = 9'h077;
        #1;
        check("brhz_fl_stall", stall1, 0);
        check("brhz_fl_issue", issue1, 0);
        check("brhz_pc_load", pc_load1, 1);
        check("brhz_pc_trgt", pc_trgt1, 9'h055);
        step();
        br_taken = 1'b0;
        check("brhz_no_2nd_load", pc_load1, 0);
        check("brhz_trgt_kept", pc_trgt1, 9'h055);
        check("brhz_flush2", flush1, 1);

        // Asynchronous reset in the second flush cycle
        rst = 1'b0;
        #1;
        check("arst_flush", flush1, 0);
        check("arst_pc_load", pc_load1, 0);
        check("arst_pc_trgt", pc_trgt1, 0);
        check("arst_cnt", cnt1, 0);
        check("arst_issue", issue1, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_issue", issue1, 1);
        check("rel_stall", stall1, 0);
        step();
        check("rel_flush", flush1, 0);
        check("rel_pc_load", pc_load1, 0);
        dec(0, 0, 0, 0, 0, 0, 0);
        step();

        // Squash depth on the BR_FLUSH=1 build
        dec(1, 0, 0, 0, 0, 19, 1);
        step();
        dec(1, 0, 0, 0, 0, 20, 1);
        step();
        dec(1, 0, 0, 0, 0, 21, 1);
        step();
        dec(1, 0, 0, 0, 0, 22, 1);
        br_taken = 1'b1;
        br_trgt  = 9'h1C3;
        step();
        br_taken = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0);
        check("sq_flush", flush2, 1);
        check("sq_pc_load", pc_load2, 1);
        check("sq_pc_trgt", pc_trgt2, 9'h1C3);
        step();
        check("sq_flush_end", flush2, 0);
        dec(1, 20, 1, 0, 0, 0, 0);
        #1 check("sq_r20", stall2, 0);
        id_rs = 5'd21;
        #1 check("sq_r21", stall2, 0);
        id_rs = 5'd22;
        #1 check("sq_r22", stall2, 0);
        dec(0, 0, 0, 0, 0, 0, 0);
        repeat (5) step();

        // Stall counter saturation: self-dependent writer of r1
        check("sat_cnt_start", cnt2, 0);
        dec(1, 1, 1, 0, 0, 1, 1);
        repeat (5) step();
        check("sat_cnt_4", cnt2, 4);
        repeat (25) step();
        check("sat_cnt_15", cnt2, 15);
        check("wide_cnt_24", cnt1, 24);
        dec(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
